// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_timer
// Brief    : 640x480@60 VGA scan timing from a 2x system clock. Produces the
//            DrawX/DrawY scan position, pixel and frame ticks, latency-aligned
//            sync/blank strobes and blank-gated RGB capture.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_timer #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int LATENCY = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       in_visible,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
    localparam logic [9:0] c_H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic               r_clk_div;
    logic [9:0]         r_hc;
    logic [9:0]         r_vc;
    logic [LATENCY-1:0] r_hs_dly;
    logic [LATENCY-1:0] r_vs_dly;
    logic [LATENCY-1:0] r_blank_dly;
    logic [7:0]         r_red;
    logic [7:0]         r_green;
    logic [7:0]         r_blue;

    logic w_pixel_tick;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_in_visible;
    logic w_blank_feed;

    // Reset gating keeps both ticks quiet for the whole reset cycle.
    assign w_pixel_tick = r_clk_div & ~Reset;
    assign w_in_visible = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
    assign w_hs_raw     = ~((r_hc >= c_HS_START) && (r_hc <= c_HS_END));
    assign w_vs_raw     = ~((r_vc >= c_VS_START) && (r_vc <= c_VS_END));

    // RGB is gated by the blank value that lands on VGA_BLANK_N at the same tick.
    generate
        if (LATENCY == 1) begin : g_feed_raw
            assign w_blank_feed = w_in_visible;
        end else begin : g_feed_dly
            assign w_blank_feed = r_blank_dly[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clk_div   <= 1'b0;
            r_hc        <= 10'd0;
            r_vc        <= 10'd0;
            r_hs_dly    <= '1;
            r_vs_dly    <= '1;
            r_blank_dly <= '0;
            r_red       <= 8'd0;
            r_green     <= 8'd0;
            r_blue      <= 8'd0;
        end else begin
            r_clk_div <= ~r_clk_div;
            if (w_pixel_tick) begin
                if (r_hc == c_H_LAST) begin
                    r_hc <= 10'd0;
                    if (r_vc == c_V_LAST) begin
                        r_vc <= 10'd0;
                    end else begin
                        r_vc <= r_vc + 10'd1;
                    end
                end else begin
                    r_hc <= r_hc + 10'd1;
                end

                r_hs_dly[0]    <= w_hs_raw;
                r_vs_dly[0]    <= w_vs_raw;
                r_blank_dly[0] <= w_in_visible;
                for (int i = 1; i < LATENCY; i++) begin
                    r_hs_dly[i]    <= r_hs_dly[i-1];
                    r_vs_dly[i]    <= r_vs_dly[i-1];
                    r_blank_dly[i] <= r_blank_dly[i-1];
                end

                if (w_blank_feed) begin
                    r_red   <= Red_in;
                    r_green <= Green_in;
                    r_blue  <= Blue_in;
                end else begin
                    r_red   <= 8'd0;
                    r_green <= 8'd0;
                    r_blue  <= 8'd0;
                end
            end
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign in_visible  = w_in_visible;
    assign pixel_tick  = w_pixel_tick;
    assign frame_tick  = w_pixel_tick && (r_hc == c_H_LAST) && (r_vc == c_V_LAST);
    assign VGA_CLK     = r_clk_div;
    assign VGA_HS      = r_hs_dly[LATENCY-1];
    assign VGA_VS      = r_vs_dly[LATENCY-1];
    assign VGA_BLANK_N = r_blank_dly[LATENCY-1];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_red;
    assign VGA_G       = r_green;
    assign VGA_B       = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_timer
// Brief    : Randomized bench comparing three scan timers (default LATENCY 2,
//            LATENCY 3, and a reduced geometry) against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_in = 8'd0;
    logic [7:0] g_in = 8'd0;
    logic [7:0] b_in = 8'd0;

    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_vis, a_pt, a_ft, a_vclk, a_hs, a_vs, a_bl, a_sn;
    logic b_vis, b_pt, b_ft, b_vclk, b_hs, b_vs, b_bl, b_sn;
    logic c_vis, c_pt, c_ft, c_vclk, c_hs, c_vs, c_bl, c_sn;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    vga_scan_timer dut_a (
        .Clk(clk), .Reset(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
        .DrawX(a_x), .DrawY(a_y), .in_visible(a_vis), .pixel_tick(a_pt), .frame_tick(a_ft),
        .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
    );

    vga_scan_timer #(.LATENCY(3)) dut_b (
        .Clk(clk), .Reset(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
        .DrawX(b_x), .DrawY(b_y), .in_visible(b_vis), .pixel_tick(b_pt), .frame_tick(b_ft),
        .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
    );

    // Small frame (24 x 10) so whole frames fit in a short run.
    vga_scan_timer #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .LATENCY(2)
    ) dut_c (
        .Clk(clk), .Reset(rst), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
        .DrawX(c_x), .DrawY(c_y), .in_visible(c_vis), .pixel_tick(c_pt), .frame_tick(c_ft),
        .VGA_CLK(c_vclk), .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bl), .VGA_SYNC_N(c_sn),
        .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b)
    );

    int tests = 0;
    int fails = 0;
    int m = 0;          // Clk edges since reset release
    int n = 0;          // pixel ticks since reset release
    int rgb_mode = 0;   // 0: red follows previous DrawX, G/B fixed; 1: random
    logic [23:0] hist [4];

    // Model: expected {hs, vs, blank_n} after n ticks for latency L.
    function automatic logic [2:0] exp_sync(input int nn, input int L,
                                            input int hv, input int hf, input int hsw, input int hb,
                                            input int vv, input int vf, input int vsw, input int vb);
        int ht, vt, k, x, y;
        logic hs, vs, bl;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (nn < L) return 3'b110;
        k  = nn - L;
        x  = k % ht;
        y  = (k / ht) % vt;
        hs = !(x >= hv + hf && x < hv + hf + hsw);
        vs = !(y >= vv + vf && y < vv + vf + vsw);
        bl = (x < hv) && (y < vv);
        return {hs, vs, bl};
    endfunction

    function automatic logic [2:0] exp_a(input int nn);
        return exp_sync(nn, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [2:0] exp_b(input int nn);
        return exp_sync(nn, 3, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [2:0] exp_c(input int nn);
        return exp_sync(nn, 2, 16, 2, 4, 2, 6, 1, 2, 1);
    endfunction

    function automatic logic [19:0] exp_pos(input int nn, input int ht, input int vt);
        int x, y;
        x = nn % ht;
        y = (nn / ht) % vt;
        return {10'(y), 10'(x)};
    endfunction

    function automatic logic exp_ptick();
        return !rst && (m % 2 == 1);
    endfunction

    function automatic logic exp_ftick(input int ht, input int vt);
        return exp_ptick() && (n % ht == ht - 1) && ((n / ht) % vt == vt - 1);
    endfunction

    // Captured RGB is whatever was on the inputs during the previous pixel period.
    function automatic logic [23:0] exp_rgb(input logic bl);
        return bl ? hist[(n + 3) % 4] : 24'h0;
    endfunction

    task automatic tick_clk();
        logic [19:0] p;
        @(posedge clk);
        if (rst) m = 0;
        else     m++;
        @(negedge clk);
        n = m / 2;
        if (rgb_mode == 0) begin
            p    = exp_pos(n + 799, 800, 525);
            r_in = (n == 0) ? 8'd0 : p[7:0];
            g_in = 8'hAA;
            b_in = 8'h55;
        end else begin
            {r_in, g_in, b_in} = 24'($urandom);
        end
        hist[n % 4] = {r_in, g_in, b_in};
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic e;
        rgb_mode = 1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            tests++; if ({a_y, a_x} !== 20'd0) begin fails++; $display("FAIL reset_pos: got x=%0d y=%0d, expected 0 0", a_x, a_y); end
            tests++; if ({a_hs, a_vs, a_bl, b_hs, b_vs, b_bl, c_hs, c_vs, c_bl} !== 9'b110110110) begin fails++; $display("FAIL reset_sync: got %b%b%b %b%b%b %b%b%b, expected 110 110 110", a_hs, a_vs, a_bl, b_hs, b_vs, b_bl, c_hs, c_vs, c_bl); end
            tests++; if ({a_r, a_g, a_b} !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h, expected 000000", {a_r, a_g, a_b}); end
            tests++; if ({a_vclk, a_pt, a_ft, a_sn} !== 4'b0000) begin fails++; $display("FAIL reset_ticks: got vclk/pt/ft/syncn=%b, expected 0000", {a_vclk, a_pt, a_ft, a_sn}); end
            tests++; if (a_vis !== 1'b1) begin fails++; $display("FAIL reset_vis: got %b, expected 1", a_vis); end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            e = (i % 2 == 0);
            tests++; if ({a_pt, a_vclk} !== {e, e}) begin fails++; $display("FAIL tick_cadence: clk %0d got pt=%b vclk=%b, expected %b", i + 1, a_pt, a_vclk, e); end
            tests++; if (a_x !== 10'((i + 1) / 2)) begin fails++; $display("FAIL tick_drawx: clk %0d got %0d, expected %0d", i + 1, a_x, (i + 1) / 2); end
        end
    endtask

    task automatic test_line();
        logic [19:0] pa;
        logic [2:0]  sa, sb;
        int low_a = 0, low_b = 0, fall_a = -1, fall_b = -1, fall2_a = -1, fall2_b = -1;
        apply_reset();
        rgb_mode = 0;
        for (int i = 0; i < 2 * 1700; i++) begin
            tick_clk();
            pa = exp_pos(n, 800, 525);
            sa = exp_a(n);
            sb = exp_b(n);
            tests++; if ({a_y, a_x} !== pa) begin fails++; $display("FAIL line_pos: n=%0d got (%0d,%0d), expected (%0d,%0d)", n, a_x, a_y, pa[9:0], pa[19:10]); end
            tests++; if ({a_hs, a_vs, a_bl} !== sa) begin fails++; $display("FAIL line_sync_l2: n=%0d got %b%b%b, expected %b", n, a_hs, a_vs, a_bl, sa); end
            tests++; if ({b_hs, b_vs, b_bl} !== sb) begin fails++; $display("FAIL line_sync_l3: n=%0d got %b%b%b, expected %b", n, b_hs, b_vs, b_bl, sb); end
            tests++; if (a_vis !== (pa[9:0] < 10'd640 && pa[19:10] < 10'd480)) begin fails++; $display("FAIL line_vis: n=%0d got %b", n, a_vis); end
            tests++; if ({a_pt, a_ft} !== {exp_ptick(), exp_ftick(800, 525)}) begin fails++; $display("FAIL line_ticks: m=%0d got pt=%b ft=%b, expected %b %b", m, a_pt, a_ft, exp_ptick(), exp_ftick(800, 525)); end
            if (m % 2 == 0) begin
                if (n >= 2 && n < 802 && a_hs === 1'b0) low_a++;
                if (n >= 3 && n < 803 && b_hs === 1'b0) low_b++;
                if (fall_a < 0 && a_hs === 1'b0) fall_a = n;
                if (fall_b < 0 && b_hs === 1'b0) fall_b = n;
                if (fall_a >= 0 && fall2_a < 0 && n > fall_a + 200 && a_hs === 1'b0) fall2_a = n;
                if (fall_b >= 0 && fall2_b < 0 && n > fall_b + 200 && b_hs === 1'b0) fall2_b = n;
                if (n == 800) begin
                    tests++; if (a_x !== 10'd0 || a_y !== 10'd1) begin fails++; $display("FAIL line_wrap: got (%0d,%0d), expected (0,1)", a_x, a_y); end
                end
            end
        end
        tests++; if (low_a != 96) begin fails++; $display("FAIL hs_width_l2: got %0d ticks, expected 96", low_a); end
        tests++; if (low_b != 96) begin fails++; $display("FAIL hs_width_l3: got %0d ticks, expected 96", low_b); end
        tests++; if (fall_a != 658) begin fails++; $display("FAIL hs_fall_l2: got tick %0d, expected 658", fall_a); end
        tests++; if (fall_b != 659) begin fails++; $display("FAIL hs_fall_l3: got tick %0d, expected 659", fall_b); end
        tests++; if (fall2_a - fall_a != 800) begin fails++; $display("FAIL line_period_l2: got %0d, expected 800", fall2_a - fall_a); end
        tests++; if (fall2_b - fall_b != 800) begin fails++; $display("FAIL line_period_l3: got %0d, expected 800", fall2_b - fall_b); end
    endtask

    task automatic test_rgb();
        logic [23:0] ea, eb;
        apply_reset();
        for (int i = 0; i < 2 * 1800; i++) begin
            rgb_mode = (i < 1800) ? 1 : 0;
            tick_clk();
            ea = exp_rgb(exp_a(n) & 3'b001 ? 1'b1 : 1'b0);
            eb = exp_rgb(exp_b(n) & 3'b001 ? 1'b1 : 1'b0);
            tests++; if ({a_r, a_g, a_b} !== ea) begin fails++; $display("FAIL rgb_l2: n=%0d m=%0d got %h, expected %h", n, m, {a_r, a_g, a_b}, ea); end
            tests++; if ({b_r, b_g, b_b} !== eb) begin fails++; $display("FAIL rgb_l3: n=%0d m=%0d got %h, expected %h", n, m, {b_r, b_g, b_b}, eb); end
        end
    endtask

    task automatic test_mid_reset();
        logic [19:0] pa;
        logic [2:0]  sa;
        apply_reset();
        rgb_mode = 1;
        for (int i = 0; i < 600; i++) tick_clk();
        tests++; if (a_x !== 10'd300 || a_y !== 10'd0) begin fails++; $display("FAIL midrst_pre: got (%0d,%0d), expected (300,0)", a_x, a_y); end
        rst = 1'b1;
        tick_clk();
        tests++; if ({a_y, a_x} !== 20'd0 || {a_hs, a_vs, a_bl} !== 3'b110) begin fails++; $display("FAIL midrst_state: got (%0d,%0d) sync %b%b%b, expected (0,0) 110", a_x, a_y, a_hs, a_vs, a_bl); end
        tests++; if ({a_r, a_g, a_b, a_pt, a_ft, a_vclk} !== 27'd0) begin fails++; $display("FAIL midrst_outs: got rgb=%h pt=%b ft=%b vclk=%b, expected zeros", {a_r, a_g, a_b}, a_pt, a_ft, a_vclk); end
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick_clk();
            pa = exp_pos(n, 800, 525);
            sa = exp_a(n);
            tests++; if ({a_y, a_x} !== pa) begin fails++; $display("FAIL midrst_pos: n=%0d got (%0d,%0d), expected (%0d,%0d)", n, a_x, a_y, pa[9:0], pa[19:10]); end
            tests++; if ({a_hs, a_vs, a_bl} !== sa || a_ft !== 1'b0) begin fails++; $display("FAIL midrst_sync: n=%0d got %b%b%b ft=%b, expected %b ft=0", n, a_hs, a_vs, a_bl, a_ft, sa); end
            tests++; if ({a_r, a_g, a_b} !== exp_rgb(sa[0])) begin fails++; $display("FAIL midrst_rgb: n=%0d got %h, expected %h", n, {a_r, a_g, a_b}, exp_rgb(sa[0])); end
        end
    endtask

    task automatic test_frame();
        logic [19:0] pc;
        logic [2:0]  sc;
        int pulses = 0, vs_low = 0, vs_fall = -1;
        logic found = 1'b0;
        apply_reset();
        rgb_mode = 1;
        for (int i = 0; i < 2 * 490; i++) begin
            tick_clk();
            pc = exp_pos(n, 24, 10);
            sc = exp_c(n);
            tests++; if ({c_y, c_x} !== pc) begin fails++; $display("FAIL frame_pos: n=%0d got (%0d,%0d), expected (%0d,%0d)", n, c_x, c_y, pc[9:0], pc[19:10]); end
            tests++; if ({c_hs, c_vs, c_bl} !== sc) begin fails++; $display("FAIL frame_sync: n=%0d got %b%b%b, expected %b", n, c_hs, c_vs, c_bl, sc); end
            tests++; if ({c_pt, c_ft} !== {exp_ptick(), exp_ftick(24, 10)}) begin fails++; $display("FAIL frame_ticks: m=%0d got pt=%b ft=%b, expected %b %b", m, c_pt, c_ft, exp_ptick(), exp_ftick(24, 10)); end
            tests++; if ({c_r, c_g, c_b} !== exp_rgb(sc[0])) begin fails++; $display("FAIL frame_rgb: n=%0d got %h, expected %h", n, {c_r, c_g, c_b}, exp_rgb(sc[0])); end
            if (c_ft === 1'b1) pulses++;
            if (m % 2 == 0 && n >= 2 && n < 242 && c_vs === 1'b0) vs_low++;
            if (vs_fall < 0 && c_vs === 1'b0) vs_fall = n;
        end
        tests++; if (pulses != 2) begin fails++; $display("FAIL frame_pulses: got %0d, expected 2", pulses); end
        tests++; if (vs_low != 48) begin fails++; $display("FAIL vs_width: got %0d ticks, expected 48", vs_low); end
        tests++; if (vs_fall != 170) begin fails++; $display("FAIL vs_fall: got tick %0d, expected 170", vs_fall); end

        // Land on the cycle that would carry frame_tick, then reset over it.
        for (int i = 0; i < 1000 && !found; i++) begin
            tick_clk();
            if (m % 2 == 1 && n % 240 == 239) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL frame_seek: got no frame end, expected one within 1000 clocks"); end
        tests++; if (c_ft !== 1'b1) begin fails++; $display("FAIL frame_pre_rst: got ft=%b, expected 1", c_ft); end
        rst = 1'b1;
        #1;
        tests++; if ({c_pt, c_ft} !== 2'b00) begin fails++; $display("FAIL frame_rst_gate: got pt=%b ft=%b, expected 0 0", c_pt, c_ft); end
        tick_clk();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick_clk();
            pc = exp_pos(n, 24, 10);
            tests++; if ({c_y, c_x} !== pc || c_ft !== 1'b0) begin fails++; $display("FAIL frame_resume: n=%0d got (%0d,%0d) ft=%b, expected (%0d,%0d) ft=0", n, c_x, c_y, c_ft, pc[9:0], pc[19:10]); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_rgb();
        test_mid_reset();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
